// File: rtl/cam_tag_resolver_if.sv
// Match-address stream from the tag resolver to the array controller.
// The resolver is the master (drives valid/addr/last); the controller's
// row sequencer is the slave and answers with ready.
interface cam_tag_resolver_if #(
  parameter int ADDR_WIDTH_CAM = 8
) ();

  logic                      match_valid;
  logic                      match_ready;
  logic [ADDR_WIDTH_CAM-1:0] match_addr;
  logic                      match_last;

  modport master (
    output match_valid,
    output match_addr,
    output match_last,
    input  match_ready
  );

  modport slave (
    input  match_valid,
    input  match_addr,
    input  match_last,
    output match_ready
  );

endinterface

// File: rtl/cam_tag_resolver.sv
// Multiple-match resolver for the associative cell array.
// Snapshots the per-row tag vector on capture and streams every matching
// row index, lowest first, one per accepted handshake. Also reports the
// popcount of the snapshot, whether anything matched, and an end-of-scan
// pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for capture; status from the previous scan is held
// SCAN  | match_valid high, presenting lowest pending row index
// FIN   | one-cycle done pulse, then back to IDLE
module cam_tag_resolver #(
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rstIn,
  input  logic [DATA_DEPTH-1:0] tag_row,
  input  logic                  capture,
  input  logic                  abort,
  cam_tag_resolver_if.master    m,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic                  any_match,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Registered state and outputs; *_d is the value loaded on the next edge.
  logic [DATA_DEPTH-1:0]     pending_q,  pending_d;
  logic                      valid_q,    valid_d;
  logic [ADDR_WIDTH_CAM-1:0] addr_q,     addr_d;
  logic                      last_q,     last_d;
  logic [CNT_WIDTH-1:0]      count_q,    count_d;
  logic                      any_q,      any_d;
  logic                      busy_q,     busy_d;
  logic                      done_q,     done_d;

  logic                      handshake;
  logic [DATA_DEPTH-1:0]     pending_after;

  // Index of the lowest set bit; zero when the vector is empty. Only bit
  // positions below DATA_DEPTH exist, so larger indices cannot be produced.
  function automatic logic [ADDR_WIDTH_CAM-1:0] lowest_idx(input logic [DATA_DEPTH-1:0] v);
    lowest_idx = '0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ADDR_WIDTH_CAM'(i);
    end
  endfunction

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [DATA_DEPTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      popcount = popcount + {{(CNT_WIDTH-1){1'b0}}, v[i]};
    end
  endfunction

  function automatic logic [DATA_DEPTH-1:0] clear_lowest(input logic [DATA_DEPTH-1:0] v);
    clear_lowest = v & (v - {{(DATA_DEPTH-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic is_single(input logic [DATA_DEPTH-1:0] v);
    is_single = (v != '0) && (clear_lowest(v) == '0);
  endfunction

  assign handshake     = valid_q & m.match_ready;
  assign pending_after = clear_lowest(pending_q);

  // State register plus all registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstIn) begin
      state     <= IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      count_q   <= '0;
      any_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      count_q   <= count_d;
      any_q     <= any_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state decode; abort takes priority over the final handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (capture) state_nxt = (tag_row != '0) ? SCAN : FIN;
      end
      SCAN: begin
        if (abort)                  state_nxt = FIN;
        else if (handshake && last_q) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the datapath and outputs; anything not touched holds.
  always_comb begin
    pending_d = pending_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    last_d    = last_q;
    count_d   = count_q;
    any_d     = any_q;
    case (state)
      IDLE: begin
        if (capture) begin
          pending_d = tag_row;
          count_d   = popcount(tag_row);
          any_d     = (tag_row != '0);
          valid_d   = (tag_row != '0);
          addr_d    = lowest_idx(tag_row);
          last_d    = is_single(tag_row);
        end
      end
      SCAN: begin
        if (abort) begin
          // A handshake in the same cycle still completes on the consumer
          // side; we simply drop whatever is left.
          pending_d = '0;
          valid_d   = 1'b0;
          last_d    = 1'b0;
        end else if (handshake) begin
          pending_d = pending_after;
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            valid_d = 1'b1;
            addr_d  = lowest_idx(pending_after);
            last_d  = is_single(pending_after);
          end
        end
      end
      FIN: begin
        pending_d = '0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
      end
      default: begin
        pending_d = '0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
      end
    endcase
    busy_d = (state_nxt == SCAN);
    done_d = (state_nxt == FIN);
  end

  assign m.match_valid = valid_q;
  assign m.match_addr  = addr_q;
  assign m.match_last  = last_q;
  assign match_count   = count_q;
  assign any_match     = any_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_cam_tag_resolver.sv
// Directed bench for cam_tag_resolver: reset, empty snapshot, streaming,
// back-pressure, abort, capture-while-busy and mid-scan reset.
module tb_cam_tag_resolver;

  localparam int DATA_DEPTH     = 16;
  localparam int ADDR_WIDTH_CAM = 8;
  localparam int CNT_WIDTH      = 8;

  logic                  clk = 1'b0;
  logic                  rstIn;
  logic [DATA_DEPTH-1:0] tag_row;
  logic                  capture;
  logic                  abort;
  logic [CNT_WIDTH-1:0]  match_count;
  logic                  any_match;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  cam_tag_resolver_if #(.ADDR_WIDTH_CAM(ADDR_WIDTH_CAM)) mif ();

  cam_tag_resolver #(
    .DATA_DEPTH(DATA_DEPTH),
    .ADDR_WIDTH_CAM(ADDR_WIDTH_CAM),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rstIn(rstIn),
    .tag_row(tag_row),
    .capture(capture),
    .abort(abort),
    .m(mif),
    .match_count(match_count),
    .any_match(any_match),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the stream outputs plus busy/done in one call.
  task automatic chk_strm(input string tag, input logic v, input logic [7:0] a,
                          input logic l, input logic b, input logic d);
    chk({tag, ".valid"}, 32'(mif.match_valid), 32'(v));
    if (v) begin
      chk({tag, ".addr"}, 32'(mif.match_addr), 32'(a));
      chk({tag, ".last"}, 32'(mif.match_last), 32'(l));
    end
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic do_capture(input logic [DATA_DEPTH-1:0] t);
    tag_row = t;
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  logic [7:0] exp8421 [4] = '{8'd0, 8'd5, 8'd10, 8'd15};

  initial begin
    rstIn = 1'b0; tag_row = '0; capture = 1'b0; abort = 1'b0; mif.match_ready = 1'b0;
    tick(); tick();
    chk("rst.valid", 32'(mif.match_valid), 0);
    chk("rst.addr",  32'(mif.match_addr), 0);
    chk("rst.last",  32'(mif.match_last), 0);
    chk("rst.count", 32'(match_count), 0);
    chk("rst.any",   32'(any_match), 0);
    chk("rst.busy",  32'(busy), 0);
    chk("rst.done",  32'(done), 0);
    rstIn = 1'b1;
    tick();

    // Abort in IDLE does nothing.
    abort = 1'b1; tick(); abort = 1'b0;
    chk_strm("idle_abort", 0, 0, 0, 0, 0);

    // Empty snapshot: straight to FIN.
    do_capture(16'h0000);
    chk("zero.count", 32'(match_count), 0);
    chk("zero.any",   32'(any_match), 0);
    chk_strm("zero.fin", 0, 0, 0, 0, 1);
    tick();
    chk_strm("zero.idle", 0, 0, 0, 0, 0);

    // Back-to-back streaming of 16'h8421.
    mif.match_ready = 1'b1;
    do_capture(16'h8421);
    chk("8421.count", 32'(match_count), 4);
    chk("8421.any",   32'(any_match), 1);
    for (int i = 0; i < 4; i++) begin
      chk_strm($sformatf("8421.m%0d", i), 1, exp8421[i], (i == 3), 1, 0);
      tick();
    end
    chk_strm("8421.fin", 0, 0, 0, 0, 1);
    tick();
    chk_strm("8421.idle", 0, 0, 0, 0, 0);
    chk("8421.count_hold", 32'(match_count), 4);

    // Stall: address must hold with valid high while ready is low.
    mif.match_ready = 1'b0;
    do_capture(16'h0006);
    for (int i = 0; i < 3; i++) begin
      chk_strm($sformatf("0006.stall%0d", i), 1, 8'd1, 0, 1, 0);
      if (i < 2) tick();
    end
    mif.match_ready = 1'b1;
    tick();
    chk_strm("0006.m1", 1, 8'd2, 1, 1, 0);
    tick();
    chk_strm("0006.fin", 0, 0, 0, 0, 1);
    tick();

    // Abort after two accepted matches, then a fresh single-hit capture.
    do_capture(16'hFFFF);
    chk("ffff.count", 32'(match_count), 16);
    chk_strm("ffff.m0", 1, 8'd0, 0, 1, 0);
    tick();
    chk_strm("ffff.m1", 1, 8'd1, 0, 1, 0);
    tick();
    chk_strm("ffff.m2", 1, 8'd2, 0, 1, 0);
    mif.match_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_strm("ffff.abort", 0, 0, 0, 0, 1);
    tick();
    chk_strm("ffff.idle", 0, 0, 0, 0, 0);
    mif.match_ready = 1'b1;
    do_capture(16'h0010);
    chk_strm("0010.m0", 1, 8'd4, 1, 1, 0);
    chk("0010.count", 32'(match_count), 1);
    tick();
    chk_strm("0010.fin", 0, 0, 0, 0, 1);
    tick();

    // Capture while scanning is ignored.
    do_capture(16'h00F0);
    chk_strm("00f0.m0", 1, 8'd4, 0, 1, 0);
    tag_row = 16'h0001; capture = 1'b1;
    tick();
    capture = 1'b0; tag_row = '0;
    chk_strm("00f0.m1", 1, 8'd5, 0, 1, 0);
    chk("00f0.count", 32'(match_count), 4);
    tick();
    chk_strm("00f0.m2", 1, 8'd6, 0, 1, 0);
    tick();
    chk_strm("00f0.m3", 1, 8'd7, 1, 1, 0);
    tick();
    chk_strm("00f0.fin", 0, 0, 0, 0, 1);
    chk("00f0.count_end", 32'(match_count), 4);
    tick();

    // Reset mid-scan.
    mif.match_ready = 1'b0;
    do_capture(16'h0300);
    chk_strm("0300.m0", 1, 8'd8, 0, 1, 0);
    rstIn = 1'b0;
    tick();
    rstIn = 1'b1;
    chk("mrst.valid", 32'(mif.match_valid), 0);
    chk("mrst.addr",  32'(mif.match_addr), 0);
    chk("mrst.last",  32'(mif.match_last), 0);
    chk("mrst.count", 32'(match_count), 0);
    chk("mrst.any",   32'(any_match), 0);
    chk("mrst.busy",  32'(busy), 0);
    chk("mrst.done",  32'(done), 0);
    mif.match_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_strm($sformatf("mrst.post%0d", i), 0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
